// File: rtl/wbdemux.sv
// Pipelined Wishbone B4 splitter: one master fanned out to two address-decoded slaves.
// Responses return registered; a slave switch waits until every outstanding response has come back.
module wbdemux #(
  parameter int            AW      = 32,
  parameter int            DW      = 32,
  parameter logic [AW-1:0] S0_ADDR = 32'h0000_0000,
  parameter logic [AW-1:0] S0_MASK = 32'hF000_0000,
  parameter logic [AW-1:0] S1_ADDR = 32'h1000_0000,
  parameter logic [AW-1:0] S1_MASK = 32'hF000_0000,
  parameter int            LGMAX   = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_cyc,
  input  logic            i_stb,
  input  logic            i_we,
  input  logic [AW-1:0]   i_adr,
  input  logic [DW-1:0]   i_dat,
  input  logic [DW/8-1:0] i_sel,
  output logic            o_stall,
  output logic            o_ack,
  output logic            o_err,
  output logic [DW-1:0]   o_data,
  output logic            o_s0_cyc,
  output logic            o_s0_stb,
  output logic            o_s0_we,
  output logic [AW-1:0]   o_s0_adr,
  output logic [DW-1:0]   o_s0_dat,
  output logic [DW/8-1:0] o_s0_sel,
  input  logic            i_s0_stall,
  input  logic            i_s0_ack,
  input  logic            i_s0_err,
  input  logic [DW-1:0]   i_s0_data,
  output logic            o_s1_cyc,
  output logic            o_s1_stb,
  output logic            o_s1_we,
  output logic [AW-1:0]   o_s1_adr,
  output logic [DW-1:0]   o_s1_dat,
  output logic [DW/8-1:0] o_s1_sel,
  input  logic            i_s1_stall,
  input  logic            i_s1_ack,
  input  logic            i_s1_err,
  input  logic [DW-1:0]   i_s1_data
);

  typedef enum logic [1:0] {SEL_NONE, SEL_S0, SEL_S1, SEL_BAD} sel_t;

  sel_t             r_sel, sel_next, dec_sel;
  logic [LGMAX-1:0] npending;
  logic             abort;
  logic             hit0, hit1, stb_stalled, accept, ack_next, err_next;

  // Both slaves see the same registered request; only one of them ever has cyc raised.
  logic             req_we;
  logic [AW-1:0]    req_adr;
  logic [DW-1:0]    req_dat;
  logic [DW/8-1:0]  req_sel;

  assign o_s0_we  = req_we;
  assign o_s0_adr = req_adr;
  assign o_s0_dat = req_dat;
  assign o_s0_sel = req_sel;
  assign o_s1_we  = req_we;
  assign o_s1_adr = req_adr;
  assign o_s1_dat = req_dat;
  assign o_s1_sel = req_sel;

  always_comb begin
    hit0 = (i_adr & S0_MASK) == S0_ADDR;
    hit1 = (i_adr & S1_MASK) == S1_ADDR;
    if (hit0)      dec_sel = SEL_S0;
    else if (hit1) dec_sel = SEL_S1;
    else           dec_sel = SEL_BAD;

    stb_stalled = (o_s0_stb && i_s0_stall) || (o_s1_stb && i_s1_stall);
    o_stall     = abort || stb_stalled
                  || ((dec_sel != r_sel) && (npending != '0))
                  || (npending == {LGMAX{1'b1}});
    accept      = i_cyc && i_stb && !o_stall;

    // An error, local or forwarded, outranks an ack arriving in the same cycle.
    err_next = 1'b0;
    if (i_cyc && !abort) begin
      if (accept && dec_sel == SEL_BAD) err_next = 1'b1;
      if (r_sel == SEL_S0 && i_s0_err)  err_next = 1'b1;
      if (r_sel == SEL_S1 && i_s1_err)  err_next = 1'b1;
    end
    ack_next = i_cyc && !abort && !err_next
               && ((r_sel == SEL_S0 && i_s0_ack) || (r_sel == SEL_S1 && i_s1_ack));

    sel_next = r_sel;
    if (!i_cyc)      sel_next = SEL_NONE;
    else if (accept) sel_next = dec_sel;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_sel <= SEL_NONE;
    else         r_sel <= sel_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      npending <= '0;
      abort    <= 1'b0;
      o_ack    <= 1'b0;
      o_err    <= 1'b0;
      o_data   <= '0;
      req_we   <= 1'b0;
      req_adr  <= '0;
      req_dat  <= '0;
      req_sel  <= '0;
      o_s0_cyc <= 1'b0;
      o_s0_stb <= 1'b0;
      o_s1_cyc <= 1'b0;
      o_s1_stb <= 1'b0;
    end else begin
      o_ack <= ack_next;
      o_err <= err_next;
      case (r_sel)
        SEL_S0:  o_data <= i_s0_data;
        SEL_S1:  o_data <= i_s1_data;
        default: o_data <= o_data;
      endcase

      if (accept) begin
        req_we  <= i_we;
        req_adr <= i_adr;
        req_dat <= i_dat;
        req_sel <= i_sel;
      end

      if (!i_cyc)        abort <= 1'b0;
      else if (err_next) abort <= 1'b1;

      if (!i_cyc || err_next) begin
        npending <= '0;
      end else begin
        case ({accept, ack_next})
          2'b10:   npending <= npending + 1'b1;
          2'b01:   if (npending != '0) npending <= npending - 1'b1;
          default: npending <= npending;
        endcase
      end

      if (!i_cyc || err_next) begin
        o_s0_cyc <= 1'b0;
        o_s0_stb <= 1'b0;
        o_s1_cyc <= 1'b0;
        o_s1_stb <= 1'b0;
      end else if (accept && dec_sel == SEL_S0) begin
        o_s0_cyc <= 1'b1;
        o_s0_stb <= 1'b1;
        o_s1_cyc <= 1'b0;
        o_s1_stb <= 1'b0;
      end else if (accept && dec_sel == SEL_S1) begin
        o_s1_cyc <= 1'b1;
        o_s1_stb <= 1'b1;
        o_s0_cyc <= 1'b0;
        o_s0_stb <= 1'b0;
      end else begin
        if (!i_s0_stall) o_s0_stb <= 1'b0;
        if (!i_s1_stall) o_s1_stb <= 1'b0;
      end
    end
  end

endmodule
